bf16_add_align: RTL and testbench
=================================

Name: bf16_add_align

Overview:
- Operand pre-alignment stage that sits directly upstream of bf16_add.
- Takes two raw bf16 operands and swaps them so the larger magnitude comes first.
- Right-shifts the smaller significand onto the larger exponent, keeping guard/round/sticky bits.
- Flags special cases, and pipelines the result behind a valid/ready handshake so the add datapath sees pre-aligned operands.

Parameters:
- MID_REG, default 1: 1 = register between the compare/swap and shift stages (latency 2); 0 = single register after the shift (latency 1).

Ports:
- clk        input   1   clock
- nreset     input   1   asynchronous active-low reset
- valid_i    input   1   operand pair valid
- ready_o    output  1   stage can accept an operand pair
- sa_i       input   1   sign of A
- ea_i       input   8   exponent of A
- ma_i       input   7   mantissa of A
- sb_i       input   1   sign of B
- eb_i       input   8   exponent of B
- mb_i       input   7   mantissa of B
- valid_o    output  1   aligned result valid
- ready_i    input   1   downstream accepts
- s_big_o    output  1   sign of larger-magnitude operand
- e_o        output  8   exponent of larger-magnitude operand (common exponent)
- m_big_o    output  8   {hidden, mantissa} of larger operand
- m_small_o  output  11  aligned {hidden, mantissa, G, R, S} of smaller operand
- eff_sub_o  output  1   effective subtraction (sa_i ^ sb_i)
- nan_o      output  1   result is NaN
- inf_o      output  1   result is infinity; its sign is on s_big_o

Behaviour:
- Reset: asynchronous, active-low. All valid flags and every output register clear to 0 immediately on assertion. ready_o is 1 after release.
- Reset mid-operation: in-flight transactions are dropped and are not replayed.
- Handshake:
  - Transfer in when valid_i && ready_o; transfer out when valid_o && ready_i.
  - Each register stage loads when it is empty or its consumer takes its data in the same cycle.
  - ready_o = first stage empty, or first stage advancing this cycle.
  - No bubbles at full throughput: one transaction per cycle while ready_i = 1.
  - valid_o and all data outputs hold stable while valid_o && !ready_i.
- Latency: MID_REG=1 gives 2 cycles (capacity 2). MID_REG=0 gives 1 cycle (capacity 1). Order is preserved.
- Flush-to-zero: an operand with e = 0 is zero. Its hidden bit is 0 and its mantissa is forced to 0, whatever the mantissa field holds.
- Hidden bit = 1 when 0 < e < 0xFF.
- Compare/swap:
  - Magnitude key = {e, m after FTZ}.
  - B is "big" only if key_B > key_A; on a tie A is big.
  - s_big_o and e_o come from the big operand.
- Shift:
  - d = e_big − e_small (8-bit unsigned, never negative after the swap).
  - ext = {hidden_small, m_small, 3'b000}, shifted right by d.
  - Bit 0 of m_small_o = OR of the shifted bit 0 and every bit shifted out (sticky).
  - d ≥ 11: m_small_o = {10'b0, ext != 0}.
- Specials (each output flag is a register carried with its data):
  - NaN operand = e = 0xFF with m != 0.
  - nan_o = either operand NaN, or both operands infinite with opposite signs.
  - inf_o = !nan_o and at least one operand is infinite (e = 0xFF, m = 0).
  - With a single infinite operand, s_big_o is that operand's sign. Swap ordering already guarantees the infinite operand is big.
  - Data fields are still produced normally when a flag is set.
- Both operands zero: e_o = 0, m_big_o = 0, m_small_o = 0, s_big_o = sa_i, eff_sub_o = sa_i ^ sb_i.

Test Plan:
- Equal operands: A = 0x3F80, B = 0x3F80 -> after 2 cycles (MID_REG=1): e_o = 0x7F, m_big_o = 0x80, m_small_o = 0x400, s_big_o = 0, eff_sub_o = 0, flags 0.
- Swap and near alignment: A = 0x3E00, B = 0x3F80 -> B is big: e_o = 0x7F, m_big_o = 0x80, m_small_o = 0x080 (d = 3, sticky 0).
- Far alignment and sticky:
  - A = 0x3F80, B = 0x3A81 (d = 10) -> m_small_o = 0x001.
  - A = 0x3F80, B = 0x0880 (d = 110) -> m_small_o = 0x001.
  - A = 0x3F80, B = 0x0001 (FTZ) -> m_small_o = 0x000.
- Tie with opposite signs: A = 0x3F80, B = 0xBF80 -> A big, s_big_o = 0, eff_sub_o = 1, m_small_o = 0x400.
- Specials:
  - 0x7F80 + 0xFF80 -> nan_o = 1.
  - 0x7FC0 + 0x3F80 -> nan_o = 1.
  - 0xFF80 + 0x3F80 -> inf_o = 1, s_big_o = 1, nan_o = 0.
- Backpressure and reset:
  - Hold ready_i = 0 and offer 3 back-to-back pairs -> ready_o drops after 2 accepted.
  - Release ready_i -> outputs arrive in order, no loss or duplication, outputs stable while stalled.
  - Assert nreset with 2 in flight -> valid_o = 0 immediately; ready_o = 1 after release.

Source files
------------

// File: rtl/bf16_add_align.sv
// bf16_add_align: orders two bf16 operands by magnitude and aligns the smaller one behind a valid/ready pipeline
module bf16_add_align #(
   parameter int MID_REG = 1
) (
   input  logic        clk,
   input  logic        nreset,
   input  logic        valid_i,
   output logic        ready_o,
   input  logic        sa_i,
   input  logic [7:0]  ea_i,
   input  logic [6:0]  ma_i,
   input  logic        sb_i,
   input  logic [7:0]  eb_i,
   input  logic [6:0]  mb_i,
   output logic        valid_o,
   input  logic        ready_i,
   output logic        s_big_o,
   output logic [7:0]  e_o,
   output logic [7:0]  m_big_o,
   output logic [10:0] m_small_o,
   output logic        eff_sub_o,
   output logic        nan_o,
   output logic        inf_o
);
   // payload: [35] s_big, [34:27] e_big, [26:19] m_big, [18:11] e_small, [10:3] m_small, [2] eff_sub, [1] nan, [0] inf
   logic [6:0]  w_ma, w_mb;
   logic        w_ha, w_hb, w_swap, w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_nan, w_inf;
   logic [35:0] w_p1, w_q;
   logic        w_v1q, w_load2;
   logic [7:0]  w_d;
   logic [10:0] w_ext, w_sh, w_ms;
   logic        w_lost;
   logic        r_v2;
   logic [30:0] r_out;

   // flush-to-zero, classify specials and put the larger magnitude first
   always_comb begin
      w_ma    = (ea_i == 8'h00) ? 7'h00 : ma_i;
      w_mb    = (eb_i == 8'h00) ? 7'h00 : mb_i;
      w_ha    = (ea_i != 8'h00) && (ea_i != 8'hFF);
      w_hb    = (eb_i != 8'h00) && (eb_i != 8'hFF);
      w_swap  = {eb_i, w_mb} > {ea_i, w_ma};
      w_nan_a = (ea_i == 8'hFF) && (ma_i != 7'h00);
      w_nan_b = (eb_i == 8'hFF) && (mb_i != 7'h00);
      w_inf_a = (ea_i == 8'hFF) && (ma_i == 7'h00);
      w_inf_b = (eb_i == 8'hFF) && (mb_i == 7'h00);
      w_nan   = w_nan_a || w_nan_b || (w_inf_a && w_inf_b && (sa_i ^ sb_i));
      w_inf   = !w_nan && (w_inf_a || w_inf_b);
      w_p1    = w_swap ? {sb_i, eb_i, w_hb, w_mb, ea_i, w_ha, w_ma, sa_i ^ sb_i, w_nan, w_inf}
                       : {sa_i, ea_i, w_ha, w_ma, eb_i, w_hb, w_mb, sa_i ^ sb_i, w_nan, w_inf};
   end

   // right-shift the small significand onto the common exponent; everything shifted out folds into sticky
   always_comb begin
      w_d    = w_q[34:27] - w_q[18:11];
      w_ext  = {w_q[10:3], 3'b000};
      w_sh   = w_ext >> w_d;
      w_lost = |(w_ext & ~(11'h7FF << w_d));
      w_ms   = {w_sh[10:1], w_sh[0] | w_lost};
   end

   assign w_load2 = !r_v2 || ready_i;

   generate
      if (MID_REG != 0) begin : g_mid
         logic        r_v1;
         logic [35:0] r_p1;
         assign ready_o = !r_v1 || w_load2;
         assign w_v1q   = r_v1;
         assign w_q     = r_p1;
         // compare/swap stage register, refilled whenever the shift stage can take its contents
         always_ff @(posedge clk or negedge nreset)
            if (!nreset) begin
               r_v1 <= 1'b0;
               r_p1 <= '0;
            end else if (ready_o) begin
               r_v1 <= valid_i;
               if (valid_i) r_p1 <= w_p1;
            end
      end else begin : g_flat
         assign ready_o = w_load2;
         assign w_v1q   = valid_i;
         assign w_q     = w_p1;
      end
   endgenerate

   // output register; holds while downstream stalls
   always_ff @(posedge clk or negedge nreset)
      if (!nreset) begin
         r_v2  <= 1'b0;
         r_out <= '0;
      end else if (w_load2) begin
         r_v2 <= w_v1q;
         if (w_v1q) r_out <= {w_q[35:19], w_ms, w_q[2:0]};
      end

   assign valid_o   = r_v2;
   assign s_big_o   = r_out[30];
   assign e_o       = r_out[29:22];
   assign m_big_o   = r_out[21:14];
   assign m_small_o = r_out[13:3];
   assign eff_sub_o = r_out[2];
   assign nan_o     = r_out[1];
   assign inf_o     = r_out[0];
endmodule

// File: tb/tb_bf16_add_align.sv
// tb_bf16_add_align: directed scoreboard bench for the bf16 pre-alignment stage (MID_REG = 1)
module tb_bf16_add_align;
   logic        clk = 1'b0, nreset = 1'b0, valid_i = 1'b0, ready_i = 1'b1;
   logic [15:0] a = 16'h0000, b = 16'h0000;
   logic        ready_o, valid_o, s_big_o, eff_sub_o, nan_o, inf_o;
   logic [7:0]  e_o, m_big_o;
   logic [10:0] m_small_o;
   logic [30:0] w_obs, snap;
   logic [30:0] q[$];
   int          n_chk = 0, n_pass = 0, waits = 0;

   always #5 clk = ~clk;

   bf16_add_align #(.MID_REG(1)) dut (
      .clk(clk), .nreset(nreset), .valid_i(valid_i), .ready_o(ready_o),
      .sa_i(a[15]), .ea_i(a[14:7]), .ma_i(a[6:0]),
      .sb_i(b[15]), .eb_i(b[14:7]), .mb_i(b[6:0]),
      .valid_o(valid_o), .ready_i(ready_i), .s_big_o(s_big_o), .e_o(e_o),
      .m_big_o(m_big_o), .m_small_o(m_small_o), .eff_sub_o(eff_sub_o),
      .nan_o(nan_o), .inf_o(inf_o)
   );

   assign w_obs = {s_big_o, e_o, m_big_o, m_small_o, eff_sub_o, nan_o, inf_o};

   function automatic logic [30:0] ex(input logic s, input logic [7:0] e, input logic [7:0] mb,
                                      input logic [10:0] ms, input logic eff, input logic nan, input logic inf);
      return {s, e, mb, ms, eff, nan, inf};
   endfunction

   task automatic chk(input string tag, input logic [30:0] obs, input logic [30:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // offer one pair; the expectation is queued only on the cycle it is actually accepted
   task automatic send(input logic [15:0] xa, input logic [15:0] xb, input logic [30:0] e);
      int k = 0;
      a = xa;
      b = xb;
      valid_i = 1'b1;
      @(negedge clk);
      while (!ready_o && k < 50) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         k++;
      end
      chk("accept", 31'(ready_o), 31'd1);
      waits += k;
      if (ready_o) q.push_back(e);
      @(posedge clk);
      #1;
      valid_i = 1'b0;
   endtask

   task automatic drain();
      int k = 0;
      while (q.size() != 0 && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("drain", 31'(q.size()), 31'd0);
      @(posedge clk);
      #1;
   endtask

   // scoreboard: every transfer out must match the oldest queued expectation
   always @(negedge clk)
      if (nreset && valid_o && ready_i) begin
         chk("out_expected", 31'(q.size() != 0), 31'd1);
         if (q.size() != 0) chk("out_data", w_obs, q.pop_front());
      end

   initial begin
      #12;
      chk("rst_valid", 31'(valid_o), 31'd0);
      chk("rst_data", w_obs, 31'd0);
      @(posedge clk);
      #1 nreset = 1'b1;
      @(negedge clk);
      chk("rst_ready", 31'(ready_o), 31'd1);
      @(posedge clk);
      #1;
      waits = 0;
      send(16'h3F80, 16'h3F80, ex(1'b0, 8'h7F, 8'h80, 11'h400, 1'b0, 1'b0, 1'b0));
      send(16'h3E00, 16'h3F80, ex(1'b0, 8'h7F, 8'h80, 11'h080, 1'b0, 1'b0, 1'b0));
      send(16'h3F80, 16'h3A81, ex(1'b0, 8'h7F, 8'h80, 11'h001, 1'b0, 1'b0, 1'b0));
      send(16'h3F80, 16'h0880, ex(1'b0, 8'h7F, 8'h80, 11'h001, 1'b0, 1'b0, 1'b0));
      send(16'h3F80, 16'h0001, ex(1'b0, 8'h7F, 8'h80, 11'h000, 1'b0, 1'b0, 1'b0));
      send(16'h3F80, 16'hBF80, ex(1'b0, 8'h7F, 8'h80, 11'h400, 1'b1, 1'b0, 1'b0));
      send(16'h7F80, 16'hFF80, ex(1'b0, 8'hFF, 8'h00, 11'h000, 1'b1, 1'b1, 1'b0));
      send(16'h7FC0, 16'h3F80, ex(1'b0, 8'hFF, 8'h40, 11'h001, 1'b0, 1'b1, 1'b0));
      send(16'hFF80, 16'h3F80, ex(1'b1, 8'hFF, 8'h00, 11'h001, 1'b1, 1'b0, 1'b1));
      send(16'h0000, 16'h8000, ex(1'b0, 8'h00, 8'h00, 11'h000, 1'b1, 1'b0, 1'b0));
      send(16'h8000, 16'h007F, ex(1'b1, 8'h00, 8'h00, 11'h000, 1'b1, 1'b0, 1'b0));
      send(16'h3F80, 16'h3A00, ex(1'b0, 8'h7F, 8'h80, 11'h001, 1'b0, 1'b0, 1'b0));
      send(16'h3F80, 16'h3FC0, ex(1'b0, 8'h7F, 8'hC0, 11'h400, 1'b0, 1'b0, 1'b0));
      send(16'h3F80, 16'h3D81, ex(1'b0, 8'h7F, 8'h80, 11'h041, 1'b0, 1'b0, 1'b0));
      send(16'h4000, 16'h3F81, ex(1'b0, 8'h80, 8'h80, 11'h204, 1'b0, 1'b0, 1'b0));
      chk("no_bubbles", 31'(waits), 31'd0);
      drain();
      // backpressure: two pairs fill the pipe, the third must be refused
      ready_i = 1'b0;
      send(16'h3F80, 16'h3E00, ex(1'b0, 8'h7F, 8'h80, 11'h080, 1'b0, 1'b0, 1'b0));
      send(16'h3F80, 16'h3F80, ex(1'b0, 8'h7F, 8'h80, 11'h400, 1'b0, 1'b0, 1'b0));
      a = 16'h4000;
      b = 16'h3F80;
      valid_i = 1'b1;
      @(negedge clk);
      chk("full_ready_low", 31'(ready_o), 31'd0);
      snap = w_obs;
      repeat (3) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         chk("stall_ready", 31'(ready_o), 31'd0);
         chk("stall_valid", 31'(valid_o), 31'd1);
         chk("stall_hold", w_obs, snap);
      end
      @(posedge clk);
      #1 ready_i = 1'b1;
      send(16'h4000, 16'h3F80, ex(1'b0, 8'h80, 8'h80, 11'h200, 1'b0, 1'b0, 1'b0));
      drain();
      // reset with two transactions in flight: they must vanish
      ready_i = 1'b0;
      send(16'h3F80, 16'hBF80, ex(1'b0, 8'h7F, 8'h80, 11'h400, 1'b1, 1'b0, 1'b0));
      send(16'hFF80, 16'h3F80, ex(1'b1, 8'hFF, 8'h00, 11'h001, 1'b1, 1'b0, 1'b1));
      nreset = 1'b0;
      #1;
      chk("async_rst_valid", 31'(valid_o), 31'd0);
      chk("async_rst_data", w_obs, 31'd0);
      q.delete();
      @(posedge clk);
      #1 nreset = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", 31'(ready_o), 31'd1);
      chk("post_rst_valid", 31'(valid_o), 31'd0);
      @(posedge clk);
      #1 ready_i = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("no_replay", 31'(valid_o), 31'd0);
      end
      @(posedge clk);
      #1;
      send(16'h3E00, 16'h3F80, ex(1'b0, 8'h7F, 8'h80, 11'h080, 1'b0, 1'b0, 1'b0));
      drain();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
